sysid_boot_checker: RTL and testbench
=====================================

Name: sysid_boot_checker

Overview:
Avalon-MM read master that sits directly downstream of the system ID slave. It reads the ID word (address 0) and the build timestamp word (address 1) and compares both against elaborated expectations. It presents a sticky pass/fail verdict and the captured values to boot-control logic and status LEDs. It runs once after reset when AUTO_START=1, and again on every start pulse.

Parameters:
EXPECTED_ID, 32'd7, ID word required at address 0
EXPECTED_TS, 32'd1385042754, timestamp required at address 1
CHECK_TS, 1, 1 = timestamp mismatch fails the check; 0 = timestamp captured but ignored in pass
READ_LATENCY, 0, cycles from read acceptance to valid m_readdata (0..7)
TIMEOUT, 255, max consecutive waitrequest cycles before abort (1..65535)
AUTO_START, 1, 1 = launch one check on the first cycle after reset deasserts

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to run a check
m_address  out  1  word address to sysid slave (0 = ID, 1 = timestamp)
m_read  out  1  read strobe
m_waitrequest  in  1  slave stall; 0 for slaves that never stall
m_readdata  in  32  read data from slave
busy  out  1  check in progress
done  out  1  sticky: last check finished (pass, fail or timeout)
pass  out  1  sticky: last check matched
timeout  out  1  sticky: last check aborted on waitrequest timeout
id_value  out  32  captured ID word
ts_value  out  32  captured timestamp word

Behaviour:
- Reset (reset=1 at a clock edge): state=IDLE. All outputs 0: m_read, m_address, busy, done, pass, timeout, id_value, ts_value. Wait and timeout counters cleared. Reset mid-transaction abandons the read immediately; the next cycle drives m_read=0.
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FINISH.
- IDLE -> RD_ID when start=1, or on the first post-reset cycle if AUTO_START=1. start is also honoured from FINISH. On entry to RD_ID: done, pass and timeout clear; busy=1.
- start while busy is ignored. There is no queuing.
- RD_ID: m_read=1, m_address=0. A read is accepted in a cycle with m_read=1 and m_waitrequest=0.
  - READ_LATENCY=0: capture m_readdata into id_value in the accept cycle, then go to RD_TS.
  - READ_LATENCY>0: go to LAT_ID with m_read=0, and capture on the READ_LATENCY-th cycle after acceptance, then go to RD_TS.
- RD_TS/LAT_TS: identical to RD_ID/LAT_ID, with m_address=1 and capture into ts_value. Then go to FINISH.
- Waitrequest timeout: one counter, cleared on entry to each RD_* state and incremented each cycle m_waitrequest=1. When it reaches TIMEOUT, go to FINISH with timeout=1 and pass=0. m_read drops the next cycle. The value not yet read keeps its prior content (0 after a fresh reset).
- FINISH (1 cycle): done=1, busy=0.
  - pass = (id_value==EXPECTED_ID) && (!CHECK_TS || ts_value==EXPECTED_TS) && !timeout.
  - Then go to IDLE. done, pass and timeout hold until the next run starts or reset asserts.
- m_address holds its last value when m_read=0.
- Compare is a full 32-bit equality. Counters are sized for TIMEOUT and READ_LATENCY, and saturate rather than wrap.
- Zero-stall latency, READ_LATENCY=0:
  - start sampled at cycle 0.
  - Cycle 1: read address 0.
  - Cycle 2: read address 1.
  - Cycle 3: FINISH.
  - done/pass are visible from cycle 4.
  - General formula: 4 + 2*READ_LATENCY + total waitrequest cycles.
- reset and start together: reset wins.

Test Plan:
- Slave returns 7 at addr 0 and 1385042754 at addr 1, no waitrequest, READ_LATENCY=0, AUTO_START=1 -> m_read high cycles 1-2 after reset release; done=1, pass=1, id_value=7, ts_value=1385042754 from cycle 4.
- Slave returns 8 at addr 0 -> done=1, pass=0, timeout=0, id_value=8. Repeat with correct ID but timestamp 0 and CHECK_TS=1 -> pass=0; with CHECK_TS=0 -> pass=1.
- waitrequest held 3 cycles on each read, READ_LATENCY=2 -> m_read held through the stalls, data captured 2 cycles after each accept, done asserts 14 cycles after start.
- waitrequest stuck high, TIMEOUT=10 -> after 10 stall cycles on address 0: done=1, timeout=1, pass=0, ts_value=0, m_read=0 the next cycle.
- reset asserted while RD_TS is stalled -> next cycle all outputs 0, m_read=0. After release with AUTO_START=0, no read occurs until start; start then yields a normal pass.
- start pulsed while busy, then again after done -> first pulse ignored. Second pulse clears done/pass for the run and reruns both reads.

Source files
------------

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker
//   Avalon-MM read master that reads the system ID slave (address 0 = ID word,
//   address 1 = build timestamp), compares both against elaborated values and
//   presents a sticky verdict. Runs once after reset when AUTO_START=1, and
//   again on every start pulse seen while not busy.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   start          in   single-cycle run request (ignored while busy)
//   m_address      out  word address (0 = ID, 1 = timestamp), held when idle
//   m_read         out  read strobe
//   m_waitrequest  in   slave stall
//   m_readdata     in   32-bit read data
//   busy           out  check in progress
//   done           out  sticky: last check finished
//   pass           out  sticky: last check matched
//   timeout        out  sticky: last check aborted on waitrequest timeout
//   id_value       out  captured ID word
//   ts_value       out  captured timestamp word
module sysid_boot_checker #(
   parameter logic [31:0] EXPECTED_ID  = 32'd7,
   parameter logic [31:0] EXPECTED_TS  = 32'd1385042754,
   parameter bit          CHECK_TS     = 1'b1,
   parameter int unsigned READ_LATENCY = 0,
   parameter int unsigned TIMEOUT      = 255,
   parameter bit          AUTO_START   = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        m_address,
   output logic        m_read,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [2:0] {
      IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FINISH
   } state_t;

   // Abort fires on the TIMEOUT-th consecutive stall cycle.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
   // Capture happens on the READ_LATENCY-th cycle after acceptance.
   localparam logic [2:0]  LAT_LAST  = 3'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

   state_t      state, state_next;
   logic        auto_pend;
   logic [15:0] wait_cnt;
   logic [2:0]  lat_cnt;
   logic        launch, cap_id, cap_ts, abort;
   logic        accept, stall_last;

   assign m_read     = (state == RD_ID) || (state == RD_TS);
   assign busy       = m_read || (state == LAT_ID) || (state == LAT_TS);
   assign accept     = m_read && !m_waitrequest;
   assign stall_last = m_read && m_waitrequest && (wait_cnt == WAIT_LAST);

   always_comb begin
      state_next = state;
      launch     = 1'b0;
      cap_id     = 1'b0;
      cap_ts     = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (start || (AUTO_START && auto_pend)) begin
               launch     = 1'b1;
               state_next = RD_ID;
            end
         end
         RD_ID: begin
            if (stall_last) begin
               abort      = 1'b1;
               state_next = FINISH;
            end else if (accept) begin
               if (READ_LATENCY == 0) begin
                  cap_id     = 1'b1;
                  state_next = RD_TS;
               end else begin
                  state_next = LAT_ID;
               end
            end
         end
         LAT_ID: begin
            if (lat_cnt == LAT_LAST) begin
               cap_id     = 1'b1;
               state_next = RD_TS;
            end
         end
         RD_TS: begin
            if (stall_last) begin
               abort      = 1'b1;
               state_next = FINISH;
            end else if (accept) begin
               if (READ_LATENCY == 0) begin
                  cap_ts     = 1'b1;
                  state_next = FINISH;
               end else begin
                  state_next = LAT_TS;
               end
            end
         end
         LAT_TS: begin
            if (lat_cnt == LAT_LAST) begin
               cap_ts     = 1'b1;
               state_next = FINISH;
            end
         end
         FINISH: begin
            if (start) begin
               launch     = 1'b1;
               state_next = RD_ID;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         auto_pend <= 1'b1;
         wait_cnt  <= '0;
         lat_cnt   <= '0;
         m_address <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         timeout   <= 1'b0;
         id_value  <= '0;
         ts_value  <= '0;
      end else begin
         state     <= state_next;
         auto_pend <= 1'b0;

         // Both counters restart on every state entry and saturate otherwise.
         if (state_next != state) begin
            wait_cnt <= '0;
            lat_cnt  <= '0;
         end else begin
            if (m_read && m_waitrequest && (wait_cnt != '1))
               wait_cnt <= wait_cnt + 16'd1;
            if (((state == LAT_ID) || (state == LAT_TS)) && (lat_cnt != '1))
               lat_cnt <= lat_cnt + 3'd1;
         end

         if (launch)
            m_address <= 1'b0;
         else if ((state_next == RD_TS) && (state != RD_TS))
            m_address <= 1'b1;

         if (cap_id) id_value <= m_readdata;
         if (cap_ts) ts_value <= m_readdata;

         if (abort) timeout <= 1'b1;

         // A restart requested from FINISH discards this verdict.
         if (launch) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
         end else if (state == FINISH) begin
            done <= 1'b1;
            pass <= (id_value == EXPECTED_ID) &&
                    (!CHECK_TS || (ts_value == EXPECTED_TS)) && !timeout;
         end
      end
   end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Self-checking bench for sysid_boot_checker. Two instances with different
// elaborations share the clock; each has its own Avalon slave model with a
// programmable stall count per address and a configurable read latency.
module tb_sysid_boot_checker;

   localparam logic [31:0] EXP_ID = 32'd7;
   localparam logic [31:0] EXP_TS = 32'd1385042754;
   localparam int LAT_A = 0;
   localparam int TO_A  = 10;
   localparam int LAT_B = 2;
   localparam int TO_B  = 255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        start [2];
   logic        m_read [2];
   logic        m_address [2];
   logic        waitreq [2];
   logic [31:0] rdata [2];
   logic        busy [2];
   logic        done [2];
   logic        pass [2];
   logic        tmo [2];
   logic [31:0] id_v [2];
   logic [31:0] ts_v [2];

   // slave contents / stall plan, and the bench's view of captured values
   logic [31:0] mem_id [2];
   logic [31:0] mem_ts [2];
   int          tgt_id [2];
   int          tgt_ts [2];
   logic [31:0] mdl_id [2];
   logic [31:0] mdl_ts [2];

   int n_checks = 0;
   int n_errors = 0;

   sysid_boot_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1),
      .READ_LATENCY(LAT_A), .TIMEOUT(TO_A), .AUTO_START(1'b1)
   ) u_dut_a (
      .clock(clk), .reset(rst[0]), .start(start[0]),
      .m_address(m_address[0]), .m_read(m_read[0]),
      .m_waitrequest(waitreq[0]), .m_readdata(rdata[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timeout(tmo[0]),
      .id_value(id_v[0]), .ts_value(ts_v[0])
   );

   sysid_boot_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0),
      .READ_LATENCY(LAT_B), .TIMEOUT(TO_B), .AUTO_START(1'b0)
   ) u_dut_b (
      .clock(clk), .reset(rst[1]), .start(start[1]),
      .m_address(m_address[1]), .m_read(m_read[1]),
      .m_waitrequest(waitreq[1]), .m_readdata(rdata[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timeout(tmo[1]),
      .id_value(id_v[1]), .ts_value(ts_v[1])
   );

   for (genvar g = 0; g < 2; g++) begin : g_slave
      localparam int L = (g == 0) ? LAT_A : LAT_B;
      int stall_cnt = 0;

      assign waitreq[g] = m_read[g] &&
                          (stall_cnt < (m_address[g] ? tgt_ts[g] : tgt_id[g]));

      always @(posedge clk) begin
         if (m_read[g] && waitreq[g]) stall_cnt <= stall_cnt + 1;
         else                         stall_cnt <= 0;
      end

      if (L == 0) begin : g_comb
         assign rdata[g] = m_address[g] ? mem_ts[g] : mem_id[g];
      end else begin : g_pipe
         // accepted data appears exactly L cycles later; junk otherwise
         logic [31:0] pipe [L];
         always @(posedge clk) begin
            pipe[0] <= (m_read[g] && !waitreq[g]) ?
                       (m_address[g] ? mem_ts[g] : mem_id[g]) : $urandom;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
         end
         assign rdata[g] = pipe[L-1];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(input int k);
      return (k == 0) ? LAT_A : LAT_B;
   endfunction

   function automatic int to_of(input int k);
      return (k == 0) ? TO_A : TO_B;
   endfunction

   function automatic bit chk_of(input int k);
      return (k == 0);
   endfunction

   function automatic string pfx(input int k);
      return (k == 0) ? "A." : "B.";
   endfunction

   task automatic check_zero(input int k, input string tag);
      string p;
      p = {pfx(k), tag, "."};
      check_eq({p, "m_read"},    m_read[k],    0);
      check_eq({p, "m_address"}, m_address[k], 0);
      check_eq({p, "busy"},      busy[k],      0);
      check_eq({p, "done"},      done[k],      0);
      check_eq({p, "pass"},      pass[k],      0);
      check_eq({p, "timeout"},   tmo[k],       0);
      check_eq({p, "id_value"},  id_v[k],      0);
      check_eq({p, "ts_value"},  ts_v[k],      0);
   endtask

   // Holds reset for two cycles; release happens in the caller.
   task automatic hold_reset(input int k);
      @(negedge clk);
      rst[k] = 1'b1;
      repeat (2) @(negedge clk);
      mdl_id[k] = '0;
      mdl_ts[k] = '0;
   endtask

   // One complete check: launched by start, or by releasing reset (auto-start).
   task automatic run_check(input int k, input bit use_start, input logic [31:0] id,
                            input logic [31:0] ts, input int s0, input int s1, input bit poke);
      int n, rd, exp_n, exp_rd, L, T;
      bit exp_to, exp_pass;
      string p;
      p = pfx(k);
      L = lat_of(k);
      T = to_of(k);
      mem_id[k] = id;
      mem_ts[k] = ts;
      tgt_id[k] = s0;
      tgt_ts[k] = s1;
      if (s0 >= T) begin
         exp_n = T + 2; exp_rd = T; exp_to = 1'b1;
      end else if (s1 >= T) begin
         exp_n = s0 + 3 + L + T; exp_rd = s0 + 1 + T; exp_to = 1'b1;
         mdl_id[k] = id;
      end else begin
         exp_n = 4 + 2 * L + s0 + s1; exp_rd = s0 + s1 + 2; exp_to = 1'b0;
         mdl_id[k] = id;
         mdl_ts[k] = ts;
      end
      exp_pass = !exp_to && (mdl_id[k] == EXP_ID) && (!chk_of(k) || (mdl_ts[k] == EXP_TS));

      @(negedge clk);
      if (use_start) start[k] = 1'b1;
      else           rst[k] = 1'b0;
      n  = 0;
      rd = 0;
      do begin
         @(negedge clk);
         start[k] = 1'b0;
         n++;
         if (m_read[k]) rd++;
         if (n == 1) begin
            check_eq({p, "busy_at_launch"}, busy[k], 1);
            check_eq({p, "done_clear_at_launch"}, done[k], 0);
         end
         if (poke && n == 2) start[k] = 1'b1;
      end while (!done[k] && n < 600);

      check_eq({p, "done_latency"}, n, exp_n);
      check_eq({p, "read_cycles"}, rd, exp_rd);
      check_eq({p, "done"}, done[k], 1);
      check_eq({p, "pass"}, pass[k], exp_pass);
      check_eq({p, "timeout"}, tmo[k], exp_to);
      check_eq({p, "id_value"}, id_v[k], mdl_id[k]);
      check_eq({p, "ts_value"}, ts_v[k], mdl_ts[k]);
      check_eq({p, "busy_after"}, busy[k], 0);
      check_eq({p, "m_read_after"}, m_read[k], 0);
      @(negedge clk);
      check_eq({p, "done_sticky"}, done[k], 1);
      check_eq({p, "pass_sticky"}, pass[k], exp_pass);
      check_eq({p, "no_rerun"}, m_read[k], 0);
   endtask

   task automatic idle_no_read(input int k, input string tag, input int cycles);
      int rd;
      rd = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (m_read[k]) rd++;
      end
      check_eq({pfx(k), tag}, rd, 0);
   endtask

   initial begin
      logic [31:0] rid, rts;
      int k, s0, s1, r;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; start[i] = 1'b0;
         mem_id[i] = '0; mem_ts[i] = '0;
         tgt_id[i] = 0; tgt_ts[i] = 0;
         mdl_id[i] = '0; mdl_ts[i] = '0;
      end
      repeat (3) @(negedge clk);
      check_zero(0, "reset");
      check_zero(1, "reset");

      // auto-start with a matching slave
      run_check(0, 1'b0, EXP_ID, EXP_TS, 0, 0, 1'b0);

      // no auto-start on B
      rst[1] = 1'b0;
      idle_no_read(1, "no_auto_start", 6);
      check_eq("B.idle_done", done[1], 0);

      // stalls of 3 on each read with read latency 2
      run_check(1, 1'b1, EXP_ID, EXP_TS, 3, 3, 1'b0);

      // mismatches
      run_check(0, 1'b1, 32'd8, EXP_TS, 0, 0, 1'b0);
      run_check(0, 1'b1, EXP_ID, 32'd0, 0, 0, 1'b0);
      run_check(1, 1'b1, EXP_ID, 32'd0, 0, 0, 1'b0);

      // one stall short of the timeout on each read
      run_check(0, 1'b1, EXP_ID, EXP_TS, TO_A - 1, TO_A - 1, 1'b0);

      // start while busy is ignored, then rerun after done
      run_check(0, 1'b1, EXP_ID, EXP_TS, 1, 2, 1'b1);
      run_check(0, 1'b1, EXP_ID, EXP_TS, 0, 0, 1'b0);

      // ID read stuck straight after reset: captured values stay zero
      hold_reset(0);
      check_zero(0, "reset2");
      run_check(0, 1'b0, EXP_ID, EXP_TS, 255, 0, 1'b0);
      run_check(0, 1'b1, EXP_ID, EXP_TS, 0, 0, 1'b0);
      run_check(0, 1'b1, EXP_ID, EXP_TS, 2, 255, 1'b0);

      // reset while the timestamp read is stalled
      mem_id[1] = EXP_ID; mem_ts[1] = EXP_TS;
      tgt_id[1] = 1; tgt_ts[1] = 255;
      @(negedge clk);
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      r = 0;
      while (!(m_read[1] && m_address[1]) && r < 50) begin
         @(negedge clk);
         r++;
      end
      check_eq("B.reached_rd_ts", m_read[1] && m_address[1], 1);
      repeat (2) @(negedge clk);
      rst[1] = 1'b1;
      mdl_id[1] = '0;
      mdl_ts[1] = '0;
      @(negedge clk);
      check_zero(1, "mid_reset");
      rst[1] = 1'b0;
      idle_no_read(1, "after_mid_reset", 6);
      run_check(1, 1'b1, EXP_ID, EXP_TS, 0, 0, 1'b0);

      // randomized runs
      for (int it = 0; it < 40; it++) begin
         k   = $urandom_range(0, 1);
         rid = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
         rts = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
         r   = $urandom_range(0, 11);
         s0  = (r == 0) ? to_of(k) : (r == 1) ? to_of(k) - 1 : $urandom_range(0, 4);
         r   = $urandom_range(0, 11);
         s1  = (r == 0) ? to_of(k) : (r == 1) ? to_of(k) - 1 : $urandom_range(0, 4);
         run_check(k, 1'b1, rid, rts, s0, s1, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
